contador_botones_up_down: RTL and testbench

- Front-end stimulus generator for the 0–15 up/down counter. It produces that counter's `EN`, `up` and `down` inputs.
- Takes two raw, bouncing push-button levels from the board and synchronises them.
- Debounces each button and converts every debounced press into exactly one single-cycle count command.
- Sits between the board pins and the counter; its outputs connect directly to the counter's `EN`/`up`/`down` ports on the same clock.

---
 rtl/contador_botones_up_down_if.sv | 27 ++
 rtl/contador_botones_up_down.sv | 213 +++++++++++++++++++++
 tb/tb_contador_botones_up_down.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/contador_botones_up_down_if.sv
// Raw button levels in, single-cycle count commands out.
interface contador_botones_up_down_if;
    logic btn_up;
    logic btn_down;
    logic EN;
    logic up;
    logic down;
    logic busy;

    modport master (
        output btn_up,
        output btn_down,
        input  EN,
        input  up,
        input  down,
        input  busy
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output EN,
        output up,
        output down,
        busy
    );
endinterface

// File: rtl/contador_botones_up_down.sv
// Button synchroniser, debouncer and one-pulse-per-press command FSM.
// Optional auto-repeat while a single button is held: define AUTO_REPEAT_EN.
module contador_botones_up_down #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 16,
    parameter int unsigned CNT_W           = 16
) (
    input logic                       clk,
    input logic                       rst,
    contador_botones_up_down_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PULSE_UP   = 2'd1,
        PULSE_DOWN = 2'd2,
        HOLD       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        (DEBOUNCE_CYCLES >> CNT_W) != 0 ||
        (REPEAT_DELAY >> CNT_W) != 0 ||
        (REPEAT_RATE >> CNT_W) != 0) begin : g_bad_params
        $error("contador_botones_up_down: parameter out of range");
    end

    // bit 0 = up button, bit 1 = down button
    logic [1:0]            raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

    state_t state_q, state_d;

    logic up_q, up_d;
    logic down_q, down_d;
    logic en_q, en_d;
    logic busy_q, busy_d;

    logic rpt_fire;
    logic rpt_dn_q;

    assign raw = {bus.btn_down, bus.btn_up};

    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;
        db_cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            db_cnt_q  <= db_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // simultaneous presses are a conflicting command: swallow them in HOLD
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (press_q == 2'b01) begin
                    state_d = PULSE_UP;
                end else if (press_q == 2'b10) begin
                    state_d = PULSE_DOWN;
                end else if (press_q == 2'b11) begin
                    state_d = HOLD;
                end
            end
            PULSE_UP,
            PULSE_DOWN: state_d = HOLD;
            HOLD: begin
                if (db_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_arm_q, rpt_arm_d;
    logic             rpt_dn_d;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_hold;
    logic [CNT_W-1:0] rpt_last;

    assign rpt_hold = rpt_dn_q ? (db_q == 2'b10) : (db_q == 2'b01);
    assign rpt_last = rpt_first_q ? RPT_DLY_LAST : RPT_RATE_LAST;

    // arming only happens on the PULSE_* -> HOLD path, so a
    // conflicting simultaneous press never repeats
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_arm_d   = rpt_arm_q;
        rpt_dn_d    = rpt_dn_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        unique case (state_q)
            PULSE_UP: begin
                rpt_arm_d   = 1'b1;
                rpt_dn_d    = 1'b0;
                rpt_first_d = 1'b1;
            end
            PULSE_DOWN: begin
                rpt_arm_d   = 1'b1;
                rpt_dn_d    = 1'b1;
                rpt_first_d = 1'b1;
            end
            HOLD: begin
                if (rpt_arm_q && rpt_hold) begin
                    if (rpt_cnt_q == rpt_last) begin
                        rpt_fire    = 1'b1;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                    end
                end else begin
                    rpt_arm_d = 1'b0;
                end
            end
            default: rpt_arm_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_arm_q   <= 1'b0;
            rpt_dn_q    <= 1'b0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_arm_q   <= rpt_arm_d;
            rpt_dn_q    <= rpt_dn_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
    assign rpt_dn_q = 1'b0;
`endif

    always_comb begin
        up_d   = (state_d == PULSE_UP) | (rpt_fire & ~rpt_dn_q);
        down_d = (state_d == PULSE_DOWN) | (rpt_fire & rpt_dn_q);
        en_d   = up_d | down_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
            en_q   <= en_d;
            busy_q <= busy_d;
        end
    end

    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign bus.EN   = en_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_contador_botones_up_down.sv
// Directed bench for contador_botones_up_down (DEBOUNCE_CYCLES = 4).
module tb_contador_botones_up_down;

    localparam int D = 4;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        bit rst;
        bit bu;
        bit bd;
        bit en;
        bit up;
        bit dn;
        bit busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    contador_botones_up_down_if bus_if ();

    contador_botones_up_down #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (8),
        .REPEAT_RATE    (4),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act),
                     $signed(exp));
        end
    endtask

    task automatic add_n(input int n, input bit r, input bit bu, input bit bd,
                         input bit en, input bit up, input bit dn,
                         input bit busy);
        vec_t v;
        v.rst = r;
        v.bu = bu;
        v.bd = bd;
        v.en = en;
        v.up = up;
        v.dn = dn;
        v.busy = busy;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // p0..p2: cycle indices of the first three pulses (either direction)
    task automatic run(input int n, output int n_up, output int n_dn,
                       output int p0, output int p1, output int p2,
                       output int viol);
        int np;
        n_up = 0;
        n_dn = 0;
        p0 = -1;
        p1 = -1;
        p2 = -1;
        viol = 0;
        np = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus_if.up === 1'b1) n_up++;
            if (bus_if.down === 1'b1) n_dn++;
            if (bus_if.up === 1'b1 || bus_if.down === 1'b1) begin
                if (np == 0) p0 = i;
                else if (np == 1) p1 = i;
                else if (np == 2) p2 = i;
                np++;
            end
            if ((bus_if.up & bus_if.down) !== 1'b0 ||
                bus_if.EN !== (bus_if.up | bus_if.down))
                viol++;
        end
    endtask

    initial begin
        int nu, nd, p0, p1, p2, vi, gl;

        rst = 1'b1;
        bus_if.btn_up = 1'b0;
        bus_if.btn_down = 1'b0;

        // reset with both held, then the held pair is a conflict
        add_n(3, 1, 1, 1, 0, 0, 0, 0);
        add_n(7, 0, 1, 1, 0, 0, 0, 0);
        add_n(3, 0, 1, 1, 0, 0, 0, 1);
        add_n(6, 0, 0, 0, 0, 0, 0, 1);
        add_n(3, 0, 0, 0, 0, 0, 0, 0);
        // clean up press held 20 cycles
        add_n(7, 0, 1, 0, 0, 0, 0, 0);
        add_n(1, 0, 1, 0, 1, 1, 0, 1);
        add_n(8, 0, 1, 0, 0, 0, 0, 1);
        add_n(1, 0, 1, 0, AR, AR, 0, 1);
        add_n(3, 0, 1, 0, 0, 0, 0, 1);
        // release: debounced level falls 5 edges later
        add_n(1, 0, 0, 0, AR, AR, 0, 1);
        add_n(3, 0, 0, 0, 0, 0, 0, 1);
        add_n(1, 0, 0, 0, AR, AR, 0, 1);
        add_n(1, 0, 0, 0, 0, 0, 0, 1);
        add_n(4, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus_if.btn_up = vecs[i].bu;
            bus_if.btn_down = vecs[i].bd;
            tick();
            check($sformatf("vec%0d_en", i), 32'(bus_if.EN), 32'(vecs[i].en));
            check($sformatf("vec%0d_up", i), 32'(bus_if.up), 32'(vecs[i].up));
            check($sformatf("vec%0d_down", i), 32'(bus_if.down),
                  32'(vecs[i].dn));
            check($sformatf("vec%0d_busy", i), 32'(bus_if.busy),
                  32'(vecs[i].busy));
        end

        // bouncing down button, then stable
        gl = 0;
        for (int k = 0; k < 6; k++) begin
            bus_if.btn_down = (k % 2 == 0);
            tick();
            if (bus_if.up !== 1'b0 || bus_if.down !== 1'b0) gl++;
        end
        check("bounce_no_pulse", 32'(gl), 0);
        bus_if.btn_down = 1'b1;
        run(20, nu, nd, p0, p1, p2, vi);
        check("bounce_n_down", 32'(nd), 1);
        check("bounce_n_up", 32'(nu), 0);
        check("bounce_latency", 32'(p0), 32'(D + 3));
        check("bounce_en_rule", 32'(vi), 0);
        bus_if.btn_down = 1'b0;
        run(12, nu, nd, p0, p1, p2, vi);
        check("bounce_idle_busy", 32'(bus_if.busy), 0);

        // 3-cycle glitch is too short
        bus_if.btn_down = 1'b1;
        run(3, nu, nd, p0, p1, p2, vi);
        bus_if.btn_down = 1'b0;
        run(15, nu, gl, p0, p1, p2, vi);
        check("glitch_pulses", 32'(nu + nd + gl), 0);
        check("glitch_busy", 32'(bus_if.busy), 0);

        // reset interrupts a press before its pulse
        bus_if.btn_up = 1'b1;
        run(5, nu, nd, p0, p1, p2, vi);
        check("rst_mid_before", 32'(nu), 0);
        rst = 1'b1;
        bus_if.btn_up = 1'b0;
        tick();
        rst = 1'b0;
        run(15, nu, nd, p0, p1, p2, vi);
        check("rst_mid_pulses", 32'(nu + nd), 0);
        check("rst_mid_busy", 32'(bus_if.busy), 0);

        // second button pressed while up is held
        bus_if.btn_up = 1'b1;
        run(8, nu, nd, p0, p1, p2, vi);
        check("second_first_up", 32'(nu), 1);
        check("second_first_pos", 32'(p0), 32'(D + 3));
        bus_if.btn_down = 1'b1;
        run(20, nu, nd, p0, p1, p2, vi);
        check("second_no_up", 32'(nu), 0);
        check("second_no_down", 32'(nd), 0);
        check("second_busy", 32'(bus_if.busy), 1);
        bus_if.btn_up = 1'b0;
        bus_if.btn_down = 1'b0;
        run(12, nu, nd, p0, p1, p2, vi);
        check("second_idle", 32'(bus_if.busy), 0);

        // long hold: repeats only with AUTO_REPEAT_EN
        bus_if.btn_up = 1'b1;
        run(38, nu, nd, p0, p1, p2, vi);
        check("hold_n_up", 32'(nu), AR ? 7 : 1);
        check("hold_n_down", 32'(nd), 0);
        check("hold_p0", 32'(p0), 32'(D + 3));
        check("hold_p1", 32'(p1), AR ? 32'(D + 3 + 9) : -1);
        check("hold_p2", 32'(p2), AR ? 32'(D + 3 + 13) : -1);
        check("hold_en_rule", 32'(vi), 0);
        bus_if.btn_up = 1'b0;
        run(8, nu, nd, p0, p1, p2, vi);
        run(20, nu, nd, p0, p1, p2, vi);
        check("release_stops", 32'(nu + nd), 0);
        check("release_busy", 32'(bus_if.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
